sync_fifo_param: RTL and testbench

- Single-clock, fully parametrised FIFO; the next generation of the team's FIFO buffers.
- Adds several features:
  - arbitrary depth (not restricted to powers of two)
  - occupancy count
  - programmable almost-full and almost-empty thresholds
  - synchronous flush
  - optional first-word-fall-through (FWFT) read mode
  - sticky overflow and underflow status
- Used as the standard buffer between same-clock pipeline stages and as the building block for per-channel queues.

---
 rtl/sync_fifo_param_if.sv | 34 +++
 rtl/sync_fifo_param.sv | 145 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// master drives the requests; slave is the FIFO that returns data and status.
interface sync_fifo_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
);
  logic             flush_i;
  logic             wr_en_i;
  logic [WIDTH-1:0] wdata_i;
  logic             rd_en_i;
  logic [WIDTH-1:0] rdata_o;
  logic             rvalid_o;
  logic             full_o;
  logic             empty_o;
  logic             almost_full_o;
  logic             almost_empty_o;
  logic [CNT_W-1:0] count_o;
  logic             wr_error_o;
  logic             rd_error_o;
  logic             overflow_o;
  logic             underflow_o;

  modport master (
    output flush_i, wr_en_i, wdata_i, rd_en_i,
    input  rdata_o, rvalid_o, full_o, empty_o, almost_full_o, almost_empty_o,
    input  count_o, wr_error_o, rd_error_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, wr_en_i, wdata_i, rd_en_i,
    output rdata_o, rvalid_o, full_o, empty_o, almost_full_o, almost_empty_o,
    output count_o, wr_error_o, rd_error_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO of arbitrary depth with occupancy count, thresholds,
// synchronous flush, optional first-word-fall-through and sticky error status.
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1),
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input logic               clk_i,
  input logic               rst_n_i,
  sync_fifo_param_if.slave  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be at least 2");
  end
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $fatal(1, "sync_fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;
  logic             wr_err_q;
  logic             rd_err_q;
  logic             ovf_q;
  logic             unf_q;

  logic             empty_c;
  logic             full_c;
  logic             rd_acc_c;
  logic             wr_acc_c;
  logic             wr_rej_c;
  logic             rd_rej_c;
  logic [WIDTH-1:0] rd_word_c;

  // Wrap at DEPTH-1 so non-power-of-two depths index every slot exactly once.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Accept/reject decode; flush masks both requests and their errors.
  always_comb begin
    empty_c   = (count == '0);
    full_c    = (count == CNT_FULL);
    rd_acc_c  = bus.rd_en_i & ~empty_c & ~bus.flush_i;
    wr_acc_c  = bus.wr_en_i & (~full_c | rd_acc_c) & ~bus.flush_i;
    wr_rej_c  = bus.wr_en_i & full_c & ~rd_acc_c & ~bus.flush_i;
    rd_rej_c  = bus.rd_en_i & empty_c & ~bus.flush_i;
    rd_word_c = mem[rd_ptr];
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_acc_c) begin
      mem[wr_ptr] <= bus.wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc_c) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Read register also keeps the last popped word visible once FWFT runs dry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc_c;
      if (rd_acc_c) begin
        rdata_q <= rd_word_c;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (bus.flush_i) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_err_q <= wr_rej_c;
      rd_err_q <= rd_rej_c;
      ovf_q    <= ovf_q | wr_rej_c;
      unf_q    <= unf_q | rd_rej_c;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.rdata_o  = empty_c ? rdata_q : rd_word_c;
    assign bus.rvalid_o = ~empty_c;
  end else begin : g_std
    assign bus.rdata_o  = rdata_q;
    assign bus.rvalid_o = rvalid_q;
  end

  assign bus.full_o         = full_c;
  assign bus.empty_o        = empty_c;
  assign bus.almost_full_o  = (count >= AF_CNT);
  assign bus.almost_empty_o = (count <= AE_CNT);
  assign bus.count_o        = count;
  assign bus.wr_error_o     = wr_err_q;
  assign bus.rd_error_o     = rd_err_q;
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard DEPTH=16 instance and an FWFT DEPTH=5
// instance, each shadowed by a queue model and compared every falling edge.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  int   n_tot = 0;
  int   n_pass = 0;

  logic [1:0] wr_en = '0;
  logic [1:0] rd_en = '0;
  logic [1:0] flush = '0;
  logic [7:0] wdata [2];

  logic [31:0] o_cnt [2];
  logic [7:0]  o_rdata [2];
  logic [1:0]  o_rv, o_full, o_empty, o_af, o_ae, o_we, o_re, o_ov, o_un;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  for (genvar G = 0; G < 2; G++) begin : g_i
    localparam int unsigned D  = (G == 0) ? 16 : 5;
    localparam int unsigned FW = (G == 0) ? 0 : 1;
    localparam int unsigned AF = D - 2;
    localparam int unsigned AE = 2;
    localparam int unsigned CW = $clog2(D + 1);

    sync_fifo_param_if #(.WIDTH(8), .CNT_W(CW)) bus ();

    sync_fifo_param #(.WIDTH(8), .DEPTH(D), .FWFT(FW)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
    );

    assign bus.wr_en_i = wr_en[G];
    assign bus.rd_en_i = rd_en[G];
    assign bus.flush_i = flush[G];
    assign bus.wdata_i = wdata[G];
    assign o_cnt[G]    = 32'(bus.count_o);
    assign o_rdata[G]  = bus.rdata_o;
    assign o_rv[G]     = bus.rvalid_o;
    assign o_full[G]   = bus.full_o;
    assign o_empty[G]  = bus.empty_o;
    assign o_af[G]     = bus.almost_full_o;
    assign o_ae[G]     = bus.almost_empty_o;
    assign o_we[G]     = bus.wr_error_o;
    assign o_re[G]     = bus.rd_error_o;
    assign o_ov[G]     = bus.overflow_o;
    assign o_un[G]     = bus.underflow_o;

    // Behavioural model: contents as a queue, status derived from its size.
    logic [7:0] q [$];
    logic [7:0] m_last;
    bit m_rv, m_we, m_re, m_ov, m_un;
    bit em, fu, ra, wa;
    int c;
    logic [7:0] er;
    bit erv;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        m_last = 8'h00; m_rv = 0; m_we = 0; m_re = 0; m_ov = 0; m_un = 0;
      end else if (flush[G]) begin
        q.delete();
        m_rv = 0; m_we = 0; m_re = 0; m_ov = 0; m_un = 0;
      end else begin
        em = (q.size() == 0);
        fu = (q.size() == D);
        ra = rd_en[G] && !em;
        wa = wr_en[G] && (!fu || ra);
        m_rv = ra;
        if (ra) m_last = q.pop_front();
        if (wa) q.push_back(wdata[G]);
        m_we = wr_en[G] && !wa;
        m_re = rd_en[G] && em;
        m_ov = m_ov | m_we;
        m_un = m_un | m_re;
      end
    end

    always @(negedge clk) begin
      if (run) begin
        c = q.size();
        if (FW != 0 && c != 0) er = q[0];
        else er = m_last;
        erv = (FW != 0) ? (c != 0) : m_rv;
        chk($sformatf("i%0d count", G), o_cnt[G], 32'(c));
        chk($sformatf("i%0d empty", G), 32'(o_empty[G]), 32'(c == 0));
        chk($sformatf("i%0d full", G), 32'(o_full[G]), 32'(c == D));
        chk($sformatf("i%0d almost_full", G), 32'(o_af[G]), 32'(c >= AF));
        chk($sformatf("i%0d almost_empty", G), 32'(o_ae[G]), 32'(c <= AE));
        chk($sformatf("i%0d rvalid", G), 32'(o_rv[G]), 32'(erv));
        chk($sformatf("i%0d rdata", G), 32'(o_rdata[G]), 32'(er));
        chk($sformatf("i%0d wr_error", G), 32'(o_we[G]), 32'(m_we));
        chk($sformatf("i%0d rd_error", G), 32'(o_re[G]), 32'(m_re));
        chk($sformatf("i%0d overflow", G), 32'(o_ov[G]), 32'(m_ov));
        chk($sformatf("i%0d underflow", G), 32'(o_un[G]), 32'(m_un));
      end
    end
  end

  // One clock cycle of requests on instance g; returns 1 time unit after the edge.
  task automatic cyc(input int g, input bit w, input bit r, input bit f, input logic [7:0] d);
    wr_en[g] = w; rd_en[g] = r; flush[g] = f; wdata[g] = d;
    @(posedge clk); #1;
    wr_en[g] = 1'b0; rd_en[g] = 1'b0; flush[g] = 1'b0;
  endtask

  task automatic chk_reset_state(input int g);
    chk("rst count", o_cnt[g], 32'd0);
    chk("rst empty", 32'(o_empty[g]), 32'd1);
    chk("rst full", 32'(o_full[g]), 32'd0);
    chk("rst almost_empty", 32'(o_ae[g]), 32'd1);
    chk("rst almost_full", 32'(o_af[g]), 32'd0);
    chk("rst rvalid", 32'(o_rv[g]), 32'd0);
    chk("rst rdata", 32'(o_rdata[g]), 32'd0);
    chk("rst overflow", 32'(o_ov[g]), 32'd0);
    chk("rst underflow", 32'(o_un[g]), 32'd0);
  endtask

  initial begin
    logic [7:0] e;
    wdata[0] = 8'h00;
    wdata[1] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    run = 1'b1;
    chk_reset_state(0);
    chk_reset_state(1);
    rst_n = 1'b1;

    // Fill the DEPTH=16 instance, watching the thresholds.
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 0, 8'(i + 1));
      chk("fill almost_full", 32'(o_af[0]), 32'((i + 1) >= 14));
      chk("fill full", 32'(o_full[0]), 32'(i == 15));
    end
    cyc(0, 1, 0, 0, 8'h11);
    chk("ovf wr_error", 32'(o_we[0]), 32'd1);
    chk("ovf overflow", 32'(o_ov[0]), 32'd1);
    chk("ovf count", o_cnt[0], 32'd16);
    cyc(0, 0, 0, 0, 8'h00);
    chk("ovf pulse end", 32'(o_we[0]), 32'd0);
    chk("ovf sticky", 32'(o_ov[0]), 32'd1);

    // Drain in order, one cycle of read latency.
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0, 8'h00);
      chk("drain rdata", 32'(o_rdata[0]), 32'(i + 1));
      chk("drain rvalid", 32'(o_rv[0]), 32'd1);
    end
    chk("drain empty", 32'(o_empty[0]), 32'd1);
    cyc(0, 0, 1, 0, 8'h00);
    chk("unf rd_error", 32'(o_re[0]), 32'd1);
    chk("unf underflow", 32'(o_un[0]), 32'd1);
    cyc(0, 0, 0, 0, 8'h00);
    chk("unf pulse end", 32'(o_re[0]), 32'd0);

    // Full FIFO with simultaneous write and read across pointer wrap.
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 1, 0, 8'(8'h40 + i));
      e = (i < 16) ? 8'(8'h20 + i) : 8'(8'h40 + i - 16);
      chk("pass count", o_cnt[0], 32'd16);
      chk("pass rdata", 32'(o_rdata[0]), 32'(e));
      chk("pass wr_error", 32'(o_we[0]), 32'd0);
    end

    // Flush with concurrent requests clears contents and sticky status.
    cyc(0, 0, 0, 1, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    chk("pre-flush underflow", 32'(o_un[0]), 32'd1);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 8'(8'h60 + i));
    chk("pre-flush count", o_cnt[0], 32'd6);
    cyc(0, 1, 1, 1, 8'hEE);
    chk("flush count", o_cnt[0], 32'd0);
    chk("flush empty", 32'(o_empty[0]), 32'd1);
    chk("flush wr_error", 32'(o_we[0]), 32'd0);
    chk("flush rd_error", 32'(o_re[0]), 32'd0);
    chk("flush underflow", 32'(o_un[0]), 32'd0);
    chk("flush overflow", 32'(o_ov[0]), 32'd0);

    // Asynchronous reset between edges with 7 entries stored.
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 8'(8'h70 + i));
    cyc(0, 0, 1, 0, 8'h00);
    chk("pre-rst count", o_cnt[0], 32'd6);
    chk("pre-rst rdata", 32'(o_rdata[0]), 32'h70);
    cyc(0, 1, 0, 0, 8'h77);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_state(0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    cyc(0, 1, 0, 0, 8'h3C);
    cyc(0, 0, 1, 0, 8'h00);
    chk("post-rst rdata", 32'(o_rdata[0]), 32'h3C);
    chk("post-rst rvalid", 32'(o_rv[0]), 32'd1);

    // FWFT DEPTH=5: word presented before any read request.
    cyc(1, 1, 0, 0, 8'hA5);
    chk("fwft rdata", 32'(o_rdata[1]), 32'hA5);
    chk("fwft rvalid", 32'(o_rv[1]), 32'd1);
    cyc(1, 0, 1, 0, 8'h00);
    chk("fwft pop empty", 32'(o_empty[1]), 32'd1);
    chk("fwft pop rvalid", 32'(o_rv[1]), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 0, 0, 8'(8'h50 + i));
      chk("fwft pair rdata", 32'(o_rdata[1]), 32'(8'h50 + i));
      cyc(1, 0, 1, 0, 8'h00);
      chk("fwft pair empty", 32'(o_empty[1]), 32'd1);
    end
    cyc(1, 1, 1, 0, 8'h99);
    chk("fwft empty rd_error", 32'(o_re[1]), 32'd1);
    chk("fwft empty count", o_cnt[1], 32'd1);
    cyc(1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 8'(8'h10 + i));
    chk("fwft full", 32'(o_full[1]), 32'd1);
    cyc(1, 1, 1, 0, 8'h15);
    chk("fwft pass count", o_cnt[1], 32'd5);
    chk("fwft pass rdata", 32'(o_rdata[1]), 32'h11);
    cyc(1, 1, 0, 0, 8'h16);
    chk("fwft ovf", 32'(o_we[1]), 32'd1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0, 8'h00);
    chk("fwft drained rdata", 32'(o_rdata[1]), 32'h15);

    repeat (3) @(posedge clk);
    #1;
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
